// File: rtl/letc_core_pkg.sv
// Shared LETC core types for the fetch2 stage: interstage buses, exception causes
// and the fetch2 state encoding.
package letc_core_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] instr_t;

    localparam word_t PC_INCR = 32'd4;

    typedef enum logic [3:0] {
        EXCPT_INSTR_MISALIGNED   = 4'd0,
        EXCPT_INSTR_ACCESS_FAULT = 4'd1
    } excpt_cause_t;

    typedef struct packed {
        word_t pc;
    } f1_to_f2_s;

    typedef struct packed {
        word_t        pc;
        word_t        pc_plus_4;
        instr_t       instr;
        logic         excpt_valid;
        excpt_cause_t excpt_cause;
    } f2_to_d_s;

    typedef enum logic [1:0] {
        F2_IDLE,
        F2_WAIT,
        F2_HELD,
        F2_DRAIN
    } f2_state_e;

    function automatic f2_to_d_s make_entry(word_t pc, instr_t instr, logic excpt_valid,
                                            excpt_cause_t excpt_cause);
        f2_to_d_s e;
        e.pc          = pc;
        e.pc_plus_4   = pc + PC_INCR;
        e.instr       = instr;
        e.excpt_valid = excpt_valid;
        e.excpt_cause = excpt_cause;
        return e;
    endfunction

endpackage

// File: rtl/letc_core_stage_fetch2.sv
// LETC fetch2: tracks the single outstanding I-cache fetch, flags misaligned and
// faulting fetches, and registers the result onto the f2_to_d bus for decode.
module letc_core_stage_fetch2
    import letc_core_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    output logic      stage_ready,
    input  logic      stage_flush,
    input  logic      stage_stall,
    input  logic      f1_to_f2_valid,
    input  f1_to_f2_s f1_to_f2,
    input  logic      ic_rsp_valid,
    input  instr_t    ic_rsp_instr,
    input  logic      ic_rsp_fault,
    output logic      f2_to_d_valid,
    output f2_to_d_s  f2_to_d
);

    f2_state_e state_q, state_d;
    word_t     pc_q, pc_d;
    f2_to_d_s  hold_q, hold_d;
    logic      hold_valid_q, hold_valid_d;
    f2_to_d_s  out_q;
    logic      out_valid_q;

    logic      accept;
    logic      f1_misaligned;
    logic      load_out;
    f2_to_d_s  out_entry;
    f2_to_d_s  rsp_entry;
    f2_to_d_s  mis_entry;

    assign stage_ready   = (state_q == F2_IDLE)
                         || ((state_q == F2_WAIT) && ic_rsp_valid && !stage_stall);
    assign accept        = f1_to_f2_valid && stage_ready && !stage_flush;
    assign f1_misaligned = (f1_to_f2.pc[1:0] != 2'b00);

    assign rsp_entry = make_entry(pc_q, ic_rsp_instr, ic_rsp_fault,
                                  ic_rsp_fault ? EXCPT_INSTR_ACCESS_FAULT
                                               : EXCPT_INSTR_MISALIGNED);
    assign mis_entry = make_entry(f1_to_f2.pc, 32'h0, 1'b1, EXCPT_INSTR_MISALIGNED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= F2_IDLE;
            pc_q         <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            if (stage_flush) begin
                out_valid_q <= 1'b0;
            end else if (!stage_stall) begin
                out_valid_q <= load_out;
                if (load_out) begin
                    out_q <= out_entry;
                end
            end
        end
    end

    // A misaligned PC accepted behind a completing hit parks in the hold buffer so
    // the two entries reach decode in program order.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (stage_flush) begin
            hold_valid_d = 1'b0;
            state_d = (((state_q == F2_WAIT) && !ic_rsp_valid) || (state_q == F2_DRAIN))
                    ? F2_DRAIN : F2_IDLE;
        end else begin
            case (state_q)
                F2_IDLE: begin
                    if (accept) begin
                        if (!f1_misaligned) begin
                            pc_d    = f1_to_f2.pc;
                            state_d = F2_WAIT;
                        end else if (stage_stall) begin
                            hold_d       = mis_entry;
                            hold_valid_d = 1'b1;
                            state_d      = F2_HELD;
                        end
                    end
                end
                F2_WAIT: begin
                    if (ic_rsp_valid) begin
                        if (stage_stall) begin
                            hold_d       = rsp_entry;
                            hold_valid_d = 1'b1;
                            state_d      = F2_HELD;
                        end else if (accept && f1_misaligned) begin
                            hold_d       = mis_entry;
                            hold_valid_d = 1'b1;
                            state_d      = F2_HELD;
                        end else if (accept) begin
                            pc_d = f1_to_f2.pc;
                        end else begin
                            state_d = F2_IDLE;
                        end
                    end
                end
                F2_HELD: begin
                    if (!stage_stall) begin
                        hold_valid_d = 1'b0;
                        state_d      = F2_IDLE;
                    end
                end
                F2_DRAIN: begin
                    if (ic_rsp_valid) begin
                        state_d = F2_IDLE;
                    end
                end
                default: state_d = F2_IDLE;
            endcase
        end
    end

    always_comb begin
        load_out  = 1'b0;
        out_entry = '0;
        if (!stage_flush && !stage_stall) begin
            case (state_q)
                F2_IDLE: begin
                    if (accept && f1_misaligned) begin
                        load_out  = 1'b1;
                        out_entry = mis_entry;
                    end
                end
                F2_WAIT: begin
                    if (ic_rsp_valid) begin
                        load_out  = 1'b1;
                        out_entry = rsp_entry;
                    end
                end
                F2_HELD: begin
                    load_out  = hold_valid_q;
                    out_entry = hold_q;
                end
                default: begin
                    load_out  = 1'b0;
                    out_entry = '0;
                end
            endcase
        end
    end

    assign f2_to_d_valid = out_valid_q;
    assign f2_to_d       = out_q;

    // The I-cache only answers requests fetch1 actually issued.
    ic_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        ic_rsp_valid |-> ((state_q == F2_WAIT) || (state_q == F2_DRAIN)));

endmodule
